// File: rtl/ilc_pkg.sv
// rtl/ilc_pkg.sv - shared types and default constants for the ILC sequencer
package ilc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        QUIESCE = 2'd1,
        ACTION  = 2'd2,
        HALT    = 2'd3
    } ilc_state_e;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } ilc_op_e;

    localparam int ILC_CYCLE_W    = 32;
    localparam int ILC_NUM_BP     = 4;
    localparam int ILC_QUIESCE_CY = 2;
    localparam int ILC_ACTION_CY  = 2;

    function automatic int ilc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ilc_bp_match.sv
// rtl/ilc_bp_match.sv - parallel breakpoint comparators against the upcoming cycle count
module ilc_bp_match
    import ilc_pkg::*;
#(
    parameter int CYCLE_W = ILC_CYCLE_W,
    parameter int NUM_BP  = ILC_NUM_BP
) (
    input  logic [CYCLE_W-1:0]        next_count,
    input  logic [NUM_BP*CYCLE_W-1:0] bp_value,
    input  logic [NUM_BP-1:0]         bp_valid,
    output logic [NUM_BP-1:0]         match,
    output logic                      any_match
);

    // Each enabled breakpoint fires when the count about to be reached equals its value.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = bp_valid[i] && (bp_value[i*CYCLE_W +: CYCLE_W] == next_count);
        end
        any_match = |match;
    end

endmodule

// File: rtl/ilc_seq_ctrl.sv
// rtl/ilc_seq_ctrl.sv - ILC save/restore sequencer top (ILC_STEP_EN adds single-step from HALT)
module ilc_seq_ctrl
    import ilc_pkg::*;
#(
    parameter int CYCLE_W    = ILC_CYCLE_W,
    parameter int NUM_BP     = ILC_NUM_BP,
    parameter int QUIESCE_CY = ILC_QUIESCE_CY,
    parameter int ACTION_CY  = ILC_ACTION_CY
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_req,
    input  logic                      dump_req,
    input  logic                      resume_req,
`ifdef ILC_STEP_EN
    input  logic                      step_req,
`endif
    input  logic [NUM_BP*CYCLE_W-1:0] bp_value,
    input  logic [NUM_BP-1:0]         bp_valid,
    output logic                      req_ready,
    output logic                      clk_en,
    output logic                      save,
    output logic                      restore,
    output logic                      halted,
    output logic [NUM_BP-1:0]         bp_hit,
    output logic [CYCLE_W-1:0]        cycle_count,
    output logic                      done
);

    localparam int WIN_W = $clog2(ilc_max(QUIESCE_CY, ACTION_CY)) + 1;

    ilc_state_e          state, state_nx;
    ilc_op_e             op, op_nx;
    logic                ret_halt, ret_halt_nx;
    logic [WIN_W-1:0]    win_cnt, win_nx;
    logic                step_active, step_nx;
    logic                step_go;
    logic                clk_en_nx, save_nx, restore_nx, done_nx;
    logic                halted_nx, req_ready_nx;
    logic [NUM_BP-1:0]   bp_hit_nx;
    logic [CYCLE_W-1:0]  next_count;
    logic [NUM_BP-1:0]   match;
    logic                any_match;

`ifdef ILC_STEP_EN
    assign step_go = step_req;
`else
    assign step_go = 1'b0;
`endif

    assign next_count = cycle_count + CYCLE_W'(1);

    ilc_bp_match #(
        .CYCLE_W (CYCLE_W),
        .NUM_BP  (NUM_BP)
    ) u_bp_match (
        .next_count (next_count),
        .bp_value   (bp_value),
        .bp_valid   (bp_valid),
        .match      (match),
        .any_match  (any_match)
    );

    // Next-state and next-output decode; every output is taken from a register.
    always_comb begin
        state_nx    = state;
        op_nx       = op;
        ret_halt_nx = ret_halt;
        win_nx      = win_cnt;
        step_nx     = 1'b0;
        clk_en_nx   = clk_en;
        save_nx     = save;
        restore_nx  = restore;
        done_nx     = 1'b0;
        bp_hit_nx   = bp_hit;
        case (state)
            RUN: begin
                if (load_req || dump_req) begin
                    state_nx    = QUIESCE;
                    op_nx       = load_req ? OP_LOAD : OP_DUMP;
                    ret_halt_nx = 1'b0;
                    win_nx      = WIN_W'(QUIESCE_CY - 1);
                    clk_en_nx   = 1'b0;
                end else if (any_match) begin
                    // Gate at the edge that lands on the breakpoint value.
                    state_nx  = HALT;
                    clk_en_nx = 1'b0;
                    bp_hit_nx = match;
                end
            end
            HALT: begin
                if (step_active) begin
                    // The single stepped cycle is over; close the gate again.
                    clk_en_nx = 1'b0;
                end else if (load_req || dump_req) begin
                    state_nx    = QUIESCE;
                    op_nx       = load_req ? OP_LOAD : OP_DUMP;
                    ret_halt_nx = 1'b1;
                    win_nx      = WIN_W'(QUIESCE_CY - 1);
                    clk_en_nx   = 1'b0;
                end else if (resume_req) begin
                    state_nx  = RUN;
                    clk_en_nx = 1'b1;
                    bp_hit_nx = '0;
                end else if (step_go) begin
                    clk_en_nx = 1'b1;
                    step_nx   = 1'b1;
                end
            end
            QUIESCE: begin
                clk_en_nx = 1'b0;
                if (win_cnt == '0) begin
                    state_nx = ACTION;
                    win_nx   = WIN_W'(ACTION_CY - 1);
                    if (op == OP_LOAD) begin
                        restore_nx = 1'b1;
                    end else begin
                        save_nx = 1'b1;
                    end
                end else begin
                    win_nx = win_cnt - WIN_W'(1);
                end
            end
            ACTION: begin
                clk_en_nx = 1'b0;
                if (win_cnt == '0) begin
                    state_nx   = ret_halt ? HALT : RUN;
                    save_nx    = 1'b0;
                    restore_nx = 1'b0;
                    clk_en_nx  = !ret_halt;
                    done_nx    = 1'b1;
                end else begin
                    win_nx = win_cnt - WIN_W'(1);
                end
            end
            default: begin
                state_nx  = RUN;
                clk_en_nx = 1'b1;
            end
        endcase
        halted_nx    = (state_nx == HALT);
        req_ready_nx = ((state_nx == RUN) || (state_nx == HALT)) && !step_nx;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            op          <= OP_LOAD;
            ret_halt    <= 1'b0;
            win_cnt     <= '0;
            step_active <= 1'b0;
            clk_en      <= 1'b1;
            save        <= 1'b0;
            restore     <= 1'b0;
            halted      <= 1'b0;
            bp_hit      <= '0;
            done        <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            state       <= state_nx;
            op          <= op_nx;
            ret_halt    <= ret_halt_nx;
            win_cnt     <= win_nx;
            step_active <= step_nx;
            clk_en      <= clk_en_nx;
            save        <= save_nx;
            restore     <= restore_nx;
            halted      <= halted_nx;
            bp_hit      <= bp_hit_nx;
            done        <= done_nx;
            req_ready   <= req_ready_nx;
        end
    end

    // Enabled-cycle counter: advances on every edge the DUT clock is enabled, wrapping freely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
        end else if (clk_en) begin
            cycle_count <= next_count;
        end
    end

endmodule

// File: tb/tb_ilc_seq_ctrl.sv
// tb/tb_ilc_seq_ctrl.sv - self-checking bench for ilc_seq_ctrl (ILC_STEP_EN adds step checks)
module tb_ilc_seq_ctrl;

    logic         clk;
    logic         reset_n, load_req, dump_req, resume_req;
    logic [127:0] bp_value;
    logic [3:0]   bp_valid;
    logic         req_ready, clk_en, save, restore, halted, done;
    logic [3:0]   bp_hit;
    logic [31:0]  cycle_count;

    logic         reset_n_s, load_s, dump_s, resume_s;
    logic [15:0]  bp_value_s;
    logic [3:0]   bp_valid_s;
    logic         req_ready_s, clk_en_s, save_s, restore_s, halted_s, done_s;
    logic [3:0]   bp_hit_s;
    logic [3:0]   cycle_count_s;
`ifdef ILC_STEP_EN
    logic         step_req, step_s;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] bpv;
        logic [3:0]   valid;
        logic [31:0]  exp_count;
        logic [3:0]   exp_hit;
    } bp_vec_t;

    bp_vec_t vecs[6];

    ilc_seq_ctrl u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_req    (load_req),
        .dump_req    (dump_req),
        .resume_req  (resume_req),
`ifdef ILC_STEP_EN
        .step_req    (step_req),
`endif
        .bp_value    (bp_value),
        .bp_valid    (bp_valid),
        .req_ready   (req_ready),
        .clk_en      (clk_en),
        .save        (save),
        .restore     (restore),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .cycle_count (cycle_count),
        .done        (done)
    );

    ilc_seq_ctrl #(.CYCLE_W(4), .NUM_BP(4), .QUIESCE_CY(2), .ACTION_CY(2)) u_small (
        .clk         (clk),
        .reset_n     (reset_n_s),
        .load_req    (load_s),
        .dump_req    (dump_s),
        .resume_req  (resume_s),
`ifdef ILC_STEP_EN
        .step_req    (step_s),
`endif
        .bp_value    (bp_value_s),
        .bp_valid    (bp_valid_s),
        .req_ready   (req_ready_s),
        .clk_en      (clk_en_s),
        .save        (save_s),
        .restore     (restore_s),
        .halted      (halted_s),
        .bp_hit      (bp_hit_s),
        .cycle_count (cycle_count_s),
        .done        (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_main();
        load_req   = 1'b0;
        dump_req   = 1'b0;
        resume_req = 1'b0;
`ifdef ILC_STEP_EN
        step_req   = 1'b0;
`endif
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_halt_main(input int limit, output int n);
        n = 0;
        while (!halted && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic exp_ce[6], exp_sv[6], exp_dn[6], exp_rr[6];
        logic [31:0] exp_cnt[6];
        logic exp_rs[5], exp_dn4[5];
        int n, bad, saves, restores, dones, lows;

        reset_n = 1'b1; reset_n_s = 1'b1;
        load_req = 0; dump_req = 0; resume_req = 0;
        load_s = 0; dump_s = 0; resume_s = 0;
        bp_value = '0; bp_valid = '0; bp_value_s = '0; bp_valid_s = '0;
`ifdef ILC_STEP_EN
        step_req = 0; step_s = 0;
`endif
        #1;
        reset_n = 1'b0; reset_n_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_clk_en", 64'(clk_en), 64'd1);
        check("rst_save", 64'(save), 64'd0);
        check("rst_restore", 64'(restore), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_bp_hit", 64'(bp_hit), 64'd0);
        check("rst_count", 64'(cycle_count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // T1: free run, no breakpoints
        reset_main();
        bad = 0;
        repeat (100) begin
            tick();
            if (clk_en !== 1'b1) bad++;
        end
        check("t1_clk_en_low_cycles", 64'(bad), 64'd0);
        check("t1_count", 64'(cycle_count), 64'd100);

        // T2: dump while counter reads 9 -> freezes at 10 for four gated cycles
        reset_main();
        repeat (9) tick();
        check("t2_pre_count", 64'(cycle_count), 64'd9);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        exp_ce  = '{0, 0, 0, 0, 1, 1};
        exp_sv  = '{0, 0, 1, 1, 0, 0};
        exp_dn  = '{0, 0, 0, 0, 1, 0};
        exp_rr  = '{0, 0, 0, 0, 1, 1};
        exp_cnt = '{10, 10, 10, 10, 10, 11};
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_clk_en[%0d]", k), 64'(clk_en), 64'(exp_ce[k]));
            check($sformatf("t2_save[%0d]", k), 64'(save), 64'(exp_sv[k]));
            check($sformatf("t2_restore[%0d]", k), 64'(restore), 64'd0);
            check($sformatf("t2_done[%0d]", k), 64'(done), 64'(exp_dn[k]));
            check($sformatf("t2_req_ready[%0d]", k), 64'(req_ready), 64'(exp_rr[k]));
            check($sformatf("t2_count[%0d]", k), 64'(cycle_count), 64'(exp_cnt[k]));
            tick();
        end

        // Breakpoint table: halt value and latched hit vector
        vecs[0] = '{{32'd0,  32'd0,  32'd0,  32'd5},  4'b0001, 32'd5,  4'b0001};
        vecs[1] = '{{32'd7,  32'd0,  32'd7,  32'd0},  4'b1010, 32'd7,  4'b1010};
        vecs[2] = '{{32'd0,  32'd9,  32'd0,  32'd3},  4'b0100, 32'd9,  4'b0100};
        vecs[3] = '{{32'd0,  32'd0,  32'd0,  32'd1},  4'b0001, 32'd1,  4'b0001};
        vecs[4] = '{{32'd0,  32'd0,  32'd12, 32'd20}, 4'b0011, 32'd12, 4'b0010};
        vecs[5] = '{{32'd40, 32'd40, 32'd40, 32'd40}, 4'b1111, 32'd40, 4'b1111};
        for (int v = 0; v < 6; v++) begin
            bp_value = vecs[v].bpv;
            bp_valid = vecs[v].valid;
            reset_main();
            wait_halt_main(200, n);
            check($sformatf("bp%0d_halted", v), 64'(halted), 64'd1);
            check($sformatf("bp%0d_count", v), 64'(cycle_count), 64'(vecs[v].exp_count));
            check($sformatf("bp%0d_hit", v), 64'(bp_hit), 64'(vecs[v].exp_hit));
            check($sformatf("bp%0d_clk_en", v), 64'(clk_en), 64'd0);
        end

        // T3: halt at 50 on breakpoint 2
        bp_value = {32'd0, 32'd50, 32'd0, 32'd0};
        bp_valid = 4'b0100;
        reset_main();
        wait_halt_main(200, n);
        check("t3_halted", 64'(halted), 64'd1);
        check("t3_count", 64'(cycle_count), 64'd50);
        check("t3_bp_hit", 64'(bp_hit), 64'd4);
        bp_value = {32'd0, 32'd52, 32'd0, 32'd0};
        repeat (3) tick();
        check("t3_count_frozen", 64'(cycle_count), 64'd50);
        check("t3_still_halted", 64'(halted), 64'd1);

        // T4: load from HALT returns to HALT
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        exp_rs  = '{0, 0, 1, 1, 0};
        exp_dn4 = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_restore[%0d]", k), 64'(restore), 64'(exp_rs[k]));
            check($sformatf("t4_clk_en[%0d]", k), 64'(clk_en), 64'd0);
            check($sformatf("t4_save[%0d]", k), 64'(save), 64'd0);
            check($sformatf("t4_done[%0d]", k), 64'(done), 64'(exp_dn4[k]));
            if (k < 4) tick();
        end
        check("t4_halted", 64'(halted), 64'd1);
        check("t4_count", 64'(cycle_count), 64'd50);
        check("t4_bp_hit_kept", 64'(bp_hit), 64'd4);

        // T3 continued: resume clears bp_hit, count advances on next enabled edge
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        check("t3_resume_halted", 64'(halted), 64'd0);
        check("t3_resume_bp_hit", 64'(bp_hit), 64'd0);
        check("t3_resume_clk_en", 64'(clk_en), 64'd1);
        check("t3_resume_count", 64'(cycle_count), 64'd50);
        tick();
        check("t3_count_51", 64'(cycle_count), 64'd51);
        tick();
        check("t3_new_bp_52", 64'(halted), 64'd1);

        // T5: simultaneous load+dump -> restore only; dump in QUIESCE ignored
        bp_valid = 4'b0000;
        reset_main();
        repeat (3) tick();
        load_req = 1'b1;
        dump_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        dump_req = 1'b0;
        saves = 0; restores = 0; dones = 0; lows = 0;
        for (int k = 0; k < 8; k++) begin
            if (save) saves++;
            if (restore) restores++;
            if (done) dones++;
            if (!clk_en) lows++;
            tick();
        end
        check("t5_save_cycles", 64'(saves), 64'd0);
        check("t5_restore_cycles", 64'(restores), 64'd2);
        check("t5_done_pulses", 64'(dones), 64'd1);
        check("t5_gated_cycles", 64'(lows), 64'd3);

        // T6: 4-bit counter, breakpoint 0 only matches after wrap
        bp_value_s = 16'h0000;
        bp_valid_s = 4'b0001;
        @(negedge clk);
        reset_n_s = 1'b1;
        n = 0;
        while (!halted_s && n < 40) begin
            tick();
            n++;
        end
        check("t6_halt_edges", 64'(n), 64'd16);
        check("t6_halted", 64'(halted_s), 64'd1);
        check("t6_count", 64'(cycle_count_s), 64'd0);
        check("t6_bp_hit", 64'(bp_hit_s), 64'd1);
`ifdef ILC_STEP_EN
        step_s = 1'b1;
        tick();
        step_s = 1'b0;
        check("step_clk_en", 64'(clk_en_s), 64'd1);
        check("step_halted", 64'(halted_s), 64'd1);
        tick();
        check("step_count", 64'(cycle_count_s), 64'd1);
        check("step_regated", 64'(clk_en_s), 64'd0);
        check("step_bp_hit", 64'(bp_hit_s), 64'd1);
        tick();
        check("step_count_hold", 64'(cycle_count_s), 64'd1);
`endif
        dump_s = 1'b1;
        tick();
        dump_s = 1'b0;
        tick();
        tick();
        check("t6_mid_action_save", 64'(save_s), 64'd1);
        reset_n_s = 1'b0;
        #1;
        check("t6_rst_save", 64'(save_s), 64'd0);
        check("t6_rst_clk_en", 64'(clk_en_s), 64'd1);
        check("t6_rst_count", 64'(cycle_count_s), 64'd0);
        check("t6_rst_halted", 64'(halted_s), 64'd0);
        @(negedge clk);
        reset_n_s = 1'b1;
        dones = 0;
        repeat (4) begin
            tick();
            if (done_s) dones++;
        end
        check("t6_no_done_after_reset", 64'(dones), 64'd0);
        check("t6_count_running", 64'(cycle_count_s), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
